crc_arbiter: RTL and testbench

CRC_ARBITER -- requirements
Module: crc_arbiter

---
 rtl/crc_arb_pkg.sv | 13 +
 rtl/crc_serial_engine.sv | 45 ++++
 rtl/crc_arbiter.sv | 138 +++++++++++++
 tb/tb_crc_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_arb_pkg.sv
// Shared definitions for the round-robin CRC arbiter: FSM state encoding and width defaults.
package crc_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CRC_W_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC datapath: one message bit per shift_en cycle, MSB first, CRC cleared on load.
module crc_serial_engine
    import crc_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CRC_W  = CRC_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data,
    input  logic [CRC_W-1:0]  poly,
    output logic [CRC_W-1:0]  crc
);

    logic [DATA_W-1:0] msg_reg;
    logic [CRC_W-1:0]  poly_reg;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_next;
    logic              feedback;

    always_comb begin
        feedback = crc_reg[CRC_W-1] ^ msg_reg[DATA_W-1];
        crc_next = {crc_reg[CRC_W-2:0], 1'b0} ^ (feedback ? poly_reg : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_reg  <= '0;
            poly_reg <= '0;
            crc_reg  <= '0;
        end else if (load) begin
            msg_reg  <= data;
            poly_reg <= poly;
            crc_reg  <= '0;
        end else if (shift_en) begin
            crc_reg  <= crc_next;
            msg_reg  <= {msg_reg[DATA_W-2:0], 1'b0};
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/crc_arbiter.sv
// Round-robin arbiter sharing one bit-serial CRC engine among NUM_REQ requesters.
// Optional macro CRC_ARB_PRIO0_EN gives requester 0 absolute priority without moving rr_ptr.
module crc_arbiter
    import crc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CRC_W   = CRC_W_DEF,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*CRC_W-1:0]  req_poly,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CRC_W-1:0]          out_crc,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy
);

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   out_id_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              out_valid_reg;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [CRC_W-1:0]  poly_arr [NUM_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              advance;
    logic [ID_W-1:0]   rr_next;
    logic              accept;
    logic              shift_en;
    logic [CRC_W-1:0]  crc_value;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
        assign poly_arr[gi]  = req_poly[gi*CRC_W +: CRC_W];
        assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        advance     = 1'b1;
        sum         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[ID_W-1:0];
            end
        end
`ifdef CRC_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
            advance     = 1'b0;
        end
`endif
    end

    assign rr_next  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
    assign accept   = (state_reg == ST_IDLE) && grant_found && !reset;
    assign shift_en = (state_reg == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            out_id_reg    <= '0;
            bit_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg   <= ST_SHIFT;
                        bit_cnt_reg <= '0;
                        out_id_reg  <= grant_idx;
                        if (advance) begin
                            rr_ptr_reg <= rr_next;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_reg == CNT_W'(DATA_W-1)) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // The engine is idle outside SHIFT, so its CRC register doubles as the held result.
    crc_serial_engine #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W)
    ) u_engine (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift_en (shift_en),
        .data     (data_arr[grant_idx]),
        .poly     (poly_arr[grant_idx]),
        .crc      (crc_value)
    );

    assign out_valid = out_valid_reg;
    assign out_crc   = crc_value;
    assign out_id    = out_id_reg;
    assign busy      = (state_reg != ST_IDLE) && !reset;

endmodule

// File: tb/tb_crc_arbiter.sv
// Directed self-checking bench for crc_arbiter (4 requesters, 32-bit data, 6-bit CRC).
module tb_crc_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int CRC_W   = 6;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*CRC_W-1:0]  req_poly;
    logic                      out_valid;
    logic                      out_ready;
    logic [CRC_W-1:0]          out_crc;
    logic [1:0]                out_id;
    logic                      busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    crc_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CRC_W   (CRC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_poly  (req_poly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .out_id    (out_id),
        .busy      (busy)
    );

    task automatic set_req(input int i, input logic [31:0] d, input logic [5:0] p);
        req_data[i*DATA_W +: DATA_W] = d;
        req_poly[i*CRC_W +: CRC_W]   = p;
        req_valid[i]                 = 1'b1;
    endtask

    // From the negedge of the grant cycle: pass the handshake edge, optionally drop the
    // requester, then count negedges until out_valid (first one after the handshake is 1).
    task automatic wait_result(input int i, input bit drop, output int n);
        @(posedge clk);
        @(negedge clk);
        if (drop) req_valid[i] = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_crc !== 6'h00) begin n_bad++; $display("FAIL reset_out_crc: got %h expected 00", out_crc); end
        n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        req_valid = '0;
        reset     = 1'b0;
        #1;
        $display("reset: out_valid=%b out_crc=%h out_id=%0d busy=%b", out_valid, out_crc, out_id, busy);
    endtask

    task automatic test_single(input int i, input logic [31:0] d, input logic [5:0] p,
                               input logic [5:0] exp_crc);
        logic [3:0] exp_rdy;
        int n;
        exp_rdy = 4'b0001 << i;
        @(negedge clk);
        set_req(i, d, p);
        #1;
        n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL single_ready: got %b expected %b", req_ready, exp_rdy); end
        wait_result(i, 1'b1, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL single_latency: got %0d expected 33", n); end
        n_cmp++; if (out_crc !== exp_crc) begin n_bad++; $display("FAIL single_crc: got %h expected %h", out_crc, exp_crc); end
        n_cmp++; if (out_id !== 2'(i)) begin n_bad++; $display("FAIL single_id: got %0d expected %0d", out_id, i); end
        $display("single: id=%0d data=%h poly=%h -> crc=%h latency=%0d", i, d, p, out_crc, n);
        pop_result();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [5:0] exp_crc [4] = '{6'h03, 6'h06, 6'h05, 6'h00};
        logic [3:0] exp_rdy;
        int n;
        do_reset();
        @(negedge clk);
        set_req(0, 32'h1, 6'h03);
        set_req(1, 32'h2, 6'h03);
        set_req(2, 32'h3, 6'h03);
        set_req(3, 32'h0, 6'h03);
        for (int g = 0; g < 5; g++) begin
            n = 0;
            #1;
            while (req_ready == 4'b0000 && n < 60) begin
                @(negedge clk);
                #1;
                n++;
            end
            exp_rdy = 4'b0001 << exp_order[g];
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, exp_rdy); end
            wait_result(exp_order[g], 1'b0, n);
            n_cmp++; if (out_id !== 2'(exp_order[g])) begin n_bad++; $display("FAIL rr_id%0d: got %0d expected %0d", g, out_id, exp_order[g]); end
            n_cmp++; if (out_crc !== exp_crc[exp_order[g]]) begin n_bad++; $display("FAIL rr_crc%0d: got %h expected %h", g, out_crc, exp_crc[exp_order[g]]); end
            $display("round_robin: grant %0d -> id=%0d crc=%h", g, out_id, out_crc);
            pop_result();
        end
        req_valid = '0;
        do_reset();
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        set_req(1, 32'h2, 6'h03);
        #1;
        wait_result(1, 1'b1, n);
        set_req(3, 32'h1, 6'h03);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (out_crc !== 6'h06 || out_id !== 2'd1) begin n_bad++; $display("FAIL bp_hold%0d: got crc=%h id=%0d expected crc=06 id=1", c, out_crc, out_id); end
            n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_bad++; $display("FAIL bp_ready%0d: got ready=%b busy=%b expected 0000/1", c, req_ready, busy); end
        end
        $display("backpressure: held crc=%h id=%0d for 10 cycles", out_crc, out_id);
        pop_result();
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_next_grant: got %b expected 1000", req_ready); end
        // Requester 3 withdraws before its handshake; nothing must start.
        req_valid = '0;
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_withdraw: got busy=%b expected 0", busy); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        @(negedge clk);
        set_req(0, 32'h1, 6'h03);
        #1;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (14) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_abort: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        n_cmp++; if (out_crc !== 6'h00) begin n_bad++; $display("FAIL mid_crc: got %h expected 00", out_crc); end
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_result: got %b expected 0", seen); end
        $display("reset_mid: aborted at shift cycle 15, busy=%b", busy);
        test_single(2, 32'h3, 6'h03, 6'h05);
    endtask

`ifdef CRC_ARB_PRIO0_EN
    task automatic test_prio0();
        int n;
        do_reset();
        @(negedge clk);
        set_req(0, 32'h1, 6'h03);
        set_req(2, 32'h3, 6'h03);
        for (int g = 0; g < 3; g++) begin
            n = 0;
            #1;
            while (req_ready == 4'b0000 && n < 60) begin
                @(negedge clk);
                #1;
                n++;
            end
            n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL prio0_grant%0d: got %b expected 0001", g, req_ready); end
            wait_result(0, 1'b0, n);
            n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL prio0_id%0d: got %0d expected 0", g, out_id); end
            $display("prio0: grant %0d -> id=%0d", g, out_id);
            pop_result();
        end
        req_valid = '0;
        do_reset();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_poly  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single(0, 32'h00000001, 6'h03, 6'h03);
        test_single(0, 32'h00000002, 6'h03, 6'h06);
        test_single(1, 32'h00000000, 6'h03, 6'h00);
        test_single(3, 32'hDEADBEEF, 6'h00, 6'h00);
        test_single(2, 32'h00000003, 6'h03, 6'h05);
`ifdef CRC_ARB_PRIO0_EN
        test_prio0();
`else
        test_round_robin();
`endif
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
